clip_monitor: RTL and testbench

//  Downstream consumer of the saturated 8-bit sample stream. Flags every sample at/beyond
//  the clamp limits, and raises a debounced clipping alarm after RUN_LEN consecutive

---
 rtl/clip_monitor_pkg.sv | 16 +
 rtl/clip_monitor_if.sv | 27 ++
 rtl/clip_monitor_sat_counter.sv | 22 ++
 rtl/clip_monitor.sv | 122 ++++++++++++
 tb/tb_clip_monitor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/clip_monitor_pkg.sv
// Shared types and default constants for the clip monitor.
package clip_monitor_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2,
        RECOVER = 2'd3
    } clip_state_t;

    // Default clamp limits of the upstream saturation stage
    localparam int LIMIAR_SUP_DEF = 120;
    localparam int LIMIAR_INF_DEF = -120;

endpackage

// File: rtl/clip_monitor_if.sv
// Sample stream in/out of the clip monitor plus its status outputs.
interface clip_monitor_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                     entrada_vld;
    logic signed [DATA_W-1:0] entrada;
    logic                     clear_count;
    logic                     saida_vld;
    logic signed [DATA_W-1:0] saida;
    logic                     clip_sup;
    logic                     clip_inf;
    logic                     alarme;
    logic [CNT_W-1:0]         clip_count;

    // Producer / software side
    modport master (
        output entrada_vld, entrada, clear_count,
        input  saida_vld, saida, clip_sup, clip_inf, alarme, clip_count
    );

    // Monitor side
    modport slave (
        input  entrada_vld, entrada, clear_count,
        output saida_vld, saida, clip_sup, clip_inf, alarme, clip_count
    );
endinterface

// File: rtl/clip_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at 1 so that event is not lost.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);
    // Count register: clear has priority, increment sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= en ? W'(1) : '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/clip_monitor.sv
// Flags clamped samples, debounces them into a clipping alarm and counts
// alarm entries. Samples are registered through with one cycle of latency.
module clip_monitor
    import clip_monitor_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LIMIAR_SUP = LIMIAR_SUP_DEF,
    parameter int LIMIAR_INF = LIMIAR_INF_DEF,
    parameter int RUN_LEN    = 4,
    parameter int CLEAR_LEN  = 8,
    parameter int CNT_W      = 16
) (
    input logic           clk,
    input logic           reset,
    clip_monitor_if.slave bus
);
    localparam int RC_MAX = (RUN_LEN > CLEAR_LEN) ? RUN_LEN : CLEAR_LEN;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [RC_W-1:0]         RUN_LIM   = RC_W'(RUN_LEN);
    localparam logic [RC_W-1:0]         CLEAR_LIM = RC_W'(CLEAR_LEN);
    localparam logic [RC_W-1:0]         ONE       = RC_W'(1);
    localparam logic signed [DATA_W-1:0] SUP      = DATA_W'(LIMIAR_SUP);
    localparam logic signed [DATA_W-1:0] INF      = DATA_W'(LIMIAR_INF);

    clip_state_t     state_q, state_d;
    logic [RC_W-1:0] run_q, run_d;
    logic [RC_W-1:0] calm_q, calm_d;
    logic            hit_sup, hit_inf, clipped, count_inc;

    // Both operands are signed, so these are two's-complement compares
    assign hit_sup = (bus.entrada >= SUP);
    assign hit_inf = (bus.entrada <= INF);
    assign clipped = hit_sup | hit_inf;

    // Next state and run/calm counters; nothing moves on invalid cycles
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        calm_d    = calm_q;
        count_inc = 1'b0;
        if (bus.entrada_vld) begin
            unique case (state_q)
                OK: begin
                    if (clipped) begin
                        run_d = ONE;
                        if (RUN_LEN == 1) begin
                            state_d   = ALARM;
                            count_inc = 1'b1;
                        end else begin
                            state_d = SUSPECT;
                        end
                    end
                end
                SUSPECT: begin
                    if (clipped) begin
                        run_d = run_q + ONE;
                        if (run_d == RUN_LIM) begin
                            state_d   = ALARM;
                            count_inc = 1'b1;
                        end
                    end else begin
                        state_d = OK;
                        run_d   = '0;
                    end
                end
                ALARM: begin
                    if (!clipped) begin
                        calm_d = ONE;
                        state_d = (CLEAR_LEN == 1) ? OK : RECOVER;
                    end
                end
                RECOVER: begin
                    // A re-clip resumes the same alarm episode; it is not a new entry
                    if (clipped) begin
                        state_d = ALARM;
                        calm_d  = '0;
                    end else begin
                        calm_d = calm_q + ONE;
                        if (calm_d == CLEAR_LIM) begin
                            state_d = OK;
                        end
                    end
                end
                default: state_d = OK;
            endcase
        end
    end

    // State, counters and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= OK;
            run_q         <= '0;
            calm_q        <= '0;
            bus.saida_vld <= 1'b0;
            bus.saida     <= '0;
            bus.clip_sup  <= 1'b0;
            bus.clip_inf  <= 1'b0;
            bus.alarme    <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            calm_q        <= calm_d;
            bus.saida_vld <= bus.entrada_vld;
            bus.alarme    <= (state_d == ALARM) || (state_d == RECOVER);
            if (bus.entrada_vld) begin
                bus.saida    <= bus.entrada;
                bus.clip_sup <= hit_sup;
                bus.clip_inf <= hit_inf;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_clip_count (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear_count),
        .en    (count_inc),
        .count (bus.clip_count)
    );
endmodule

// File: tb/tb_clip_monitor.sv
// Bench for clip_monitor: two instances (16-bit and 2-bit alarm counters)
// share one stimulus stream; expectations come from a table or a model.
module tb_clip_monitor;
    typedef struct {
        int svld; int saida; int sup; int inf; int al; int c16; int c2;
    } exp_t;

    typedef struct {
        int rst; int vld; int d; int clr;
        int svld; int saida; int sup; int inf; int al; int c16; int c2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clip_monitor_if #(.DATA_W(8), .CNT_W(16)) if16 ();
    clip_monitor_if #(.DATA_W(8), .CNT_W(2))  if2 ();

    clip_monitor #(.DATA_W(8), .LIMIAR_SUP(120), .LIMIAR_INF(-120), .RUN_LEN(4),
                   .CLEAR_LEN(8), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
    clip_monitor #(.DATA_W(8), .LIMIAR_SUP(120), .LIMIAR_INF(-120), .RUN_LEN(4),
                   .CLEAR_LEN(8), .CNT_W(2))  dut2  (.clk(clk), .reset(reset), .bus(if2));

    int   nvec = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // reference model state
    int   ms = 0, mrun = 0, mcalm = 0, mc16 = 0, mc2 = 0;
    exp_t mo = '{0, 0, 0, 0, 0, 0, 0};

    function automatic void chk(string nm, int act, int want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endfunction

    task automatic model_step(int rst, int vld, int d, int clr);
        bit clipped, inc;
        if (rst != 0) begin
            ms = 0; mrun = 0; mcalm = 0; mc16 = 0; mc2 = 0;
            mo = '{0, 0, 0, 0, 0, 0, 0};
            return;
        end
        clipped = (d >= 120) || (d <= -120);
        inc = 1'b0;
        mo.svld = vld;
        if (vld != 0) begin
            mo.saida = d;
            mo.sup = (d >= 120) ? 1 : 0;
            mo.inf = (d <= -120) ? 1 : 0;
            case (ms)
                0: if (clipped) begin mrun = 1; ms = 1; end
                1: if (clipped) begin
                       mrun++;
                       if (mrun == 4) begin ms = 2; inc = 1'b1; end
                   end else begin ms = 0; mrun = 0; end
                2: if (!clipped) begin mcalm = 1; ms = 3; end
                default: if (clipped) begin ms = 2; mcalm = 0; end
                         else begin mcalm++; if (mcalm == 8) ms = 0; end
            endcase
        end
        if (clr != 0) begin
            mc16 = inc ? 1 : 0;
            mc2  = inc ? 1 : 0;
        end else if (inc) begin
            if (mc16 < 65535) mc16++;
            if (mc2 < 3) mc2++;
        end
        mo.al = (ms >= 2) ? 1 : 0;
        mo.c16 = mc16;
        mo.c2 = mc2;
    endtask

    task automatic apply(string tag, int rst, int vld, int d, int clr, bit use_tbl, exp_t te);
        exp_t e;
        reset = 1'(rst);
        if16.entrada_vld = 1'(vld); if16.entrada = 8'(d); if16.clear_count = 1'(clr);
        if2.entrada_vld  = 1'(vld); if2.entrada  = 8'(d); if2.clear_count  = 1'(clr);
        model_step(rst, vld, d, clr);
        sb.push_back(use_tbl ? te : mo);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        nvec++;
        chk({tag, ".saida_vld"}, int'(if16.saida_vld), e.svld);
        chk({tag, ".saida"},     int'(if16.saida),     e.saida);
        chk({tag, ".clip_sup"},  int'(if16.clip_sup),  e.sup);
        chk({tag, ".clip_inf"},  int'(if16.clip_inf),  e.inf);
        chk({tag, ".alarme"},    int'(if16.alarme),    e.al);
        chk({tag, ".count16"},   int'(if16.clip_count), e.c16);
        chk({tag, ".count2"},    int'(if2.clip_count),  e.c2);
        chk({tag, ".alarme2"},   int'(if2.alarme),     e.al);
    endtask

    task automatic run(string tag, int vld, int d, int clr);
        apply(tag, 0, vld, d, clr, 1'b0, mo);
    endtask

    vec_t tbl[24];
    int   ep_exp[4] = '{1, 2, 3, 3};

    initial begin
        exp_t te;
        reset = 1'b1;
        if16.entrada_vld = 1'b0; if16.entrada = '0; if16.clear_count = 1'b0;
        if2.entrada_vld  = 1'b0; if2.entrada  = '0; if2.clear_count  = 1'b0;

        //            rst vld  d   clr | svld saida sup inf al c16 c2
        tbl[0]  = '{1, 0,    0, 0,  0,    0, 0, 0, 0, 0, 0};
        // reset mid-alarm
        tbl[1]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1,  120, 0,  1,  120, 1, 0, 1, 1, 1};
        tbl[5]  = '{1, 1,  120, 0,  0,    0, 0, 0, 0, 0, 0};
        // broken run then full low run
        tbl[6]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1,    0, 0,  1,    0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, -120, 0,  1, -120, 0, 1, 0, 0, 0};
        tbl[11] = '{0, 1, -120, 0,  1, -120, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, -120, 0,  1, -120, 0, 1, 0, 0, 0};
        tbl[13] = '{0, 1, -120, 0,  1, -120, 0, 1, 1, 1, 1};
        // limit boundaries, mixed-sign run
        tbl[14] = '{1, 0,    0, 0,  0,    0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 1,  119, 0,  1,  119, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 1, -119, 0,  1, -119, 0, 0, 0, 0, 0};
        tbl[17] = '{0, 1,  120, 0,  1,  120, 1, 0, 0, 0, 0};
        tbl[18] = '{0, 1, -120, 0,  1, -120, 0, 1, 0, 0, 0};
        tbl[19] = '{0, 1,  127, 0,  1,  127, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 1, -128, 0,  1, -128, 0, 1, 1, 1, 1};
        // invalid cycle holds data; clear alone zeroes count
        tbl[21] = '{0, 0,    5, 0,  0, -128, 0, 1, 1, 1, 1};
        tbl[22] = '{0, 0,    5, 1,  0, -128, 0, 1, 1, 0, 0};
        tbl[23] = '{0, 0,    5, 0,  0, -128, 0, 1, 1, 0, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            te = '{tbl[i].svld, tbl[i].saida, tbl[i].sup, tbl[i].inf,
                   tbl[i].al, tbl[i].c16, tbl[i].c2};
            apply($sformatf("v%0d", i), tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].clr, 1'b1, te);
        end

        // recover: re-clip inside RECOVER keeps alarm without counting
        for (int i = 0; i < 5; i++) run("rec_a", 1, 0, 0);
        run("rec_clip", 1, 120, 0);
        for (int i = 0; i < 8; i++) run("rec_b", 1, 0, 0);
        nvec++;
        chk("rec.alarme_off", int'(if16.alarme), 0);

        // gaps between valid clipped samples
        apply("gap_rst", 1, 0, 0, 0, 1'b0, mo);
        run("gap", 1, 120, 0); run("gap", 0, -7, 0);
        run("gap", 1, 120, 0); run("gap", 0, -7, 0);
        run("gap", 1, 120, 0); run("gap", 1, 120, 0);
        nvec++;
        chk("gap.alarme_on", int'(if16.alarme), 1);

        // counter saturation on the 2-bit instance
        apply("cnt_rst", 1, 0, 0, 0, 1'b0, mo);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) run("ep_clip", 1, -128, 0);
            for (int i = 0; i < 8; i++) run("ep_calm", 1, 3, 0);
            nvec++;
            chk($sformatf("ep%0d.count2", k), int'(if2.clip_count), ep_exp[k]);
        end
        for (int i = 0; i < 3; i++) run("clr_inc", 1, 120, 0);
        run("clr_inc", 1, 120, 1);
        nvec++;
        chk("clr_inc.count2", int'(if2.clip_count), 1);
        run("clr_only", 1, 0, 1);
        nvec++;
        chk("clr_only.count2", int'(if2.clip_count), 0);

        // randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            int sel, d, v, c, r;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: d = 120;   1: d = -120;  2: d = 127;  3: d = -128;
                4: d = 119;   5: d = -119;  default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            c = ($urandom_range(0, 22) == 0) ? 1 : 0;
            r = ($urandom_range(0, 96) == 0) ? 1 : 0;
            apply("rnd", r, v, d, c, 1'b0, mo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
        $finish;
    end
endmodule
